// File: rtl/pe_net_iface.sv
// Network interface between a processing element and its mesh switch PE port.
// TX packs requests into flits through a one-entry register; RX filters by destination into a show-ahead FIFO.
module pe_net_iface #(
    parameter int MY_X     = 0,
    parameter int MY_Y     = 0,
    parameter int RX_DEPTH = 4,
    parameter int RX_AW    = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_tx_valid,
    output logic             o_tx_ready,
    input  logic [3:0]       i_tx_dst_x,
    input  logic [3:0]       i_tx_dst_y,
    input  logic [25:0]      i_tx_payload,
    output logic             o_sw_valid,
    input  logic             i_sw_ready,
    output logic [41:0]      o_sw_data,
    input  logic             i_sw_valid,
    output logic             o_sw_ready,
    input  logic [41:0]      i_sw_data,
    output logic             o_rx_valid,
    input  logic             i_rx_ready,
    output logic [3:0]       o_rx_src_x,
    output logic [3:0]       o_rx_src_y,
    output logic [25:0]      o_rx_payload,
    output logic [RX_AW:0]   o_rx_level,
    output logic             o_misroute,
    output logic [15:0]      o_tx_count,
    output logic [15:0]      o_rx_count
);

    typedef struct packed {
        logic [3:0]  dst_x;
        logic [3:0]  dst_y;
        logic [3:0]  src_x;
        logic [3:0]  src_y;
        logic [25:0] payload;
    } flit_t;

    // Only the fields the PE sees are stored; the destination is known to be this node.
    typedef struct packed {
        logic [3:0]  src_x;
        logic [3:0]  src_y;
        logic [25:0] payload;
    } rx_entry_t;

    localparam logic [3:0]     SELF_X     = 4'(MY_X);
    localparam logic [3:0]     SELF_Y     = 4'(MY_Y);
    localparam logic [RX_AW:0] FULL_LEVEL = (RX_AW+1)'(RX_DEPTH);

    // ---------------- TX path ----------------
    flit_t sw_flit;
    logic  tx_accept;
    logic  sw_out_xfer;

    assign o_tx_ready  = !o_sw_valid || i_sw_ready;
    assign tx_accept   = i_tx_valid && o_tx_ready;
    assign sw_out_xfer = o_sw_valid && i_sw_ready;
    assign o_sw_data   = sw_flit;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_sw_valid <= 1'b0;
            sw_flit    <= '0;
            o_tx_count <= '0;
        end else begin
            if (tx_accept) begin
                o_sw_valid <= 1'b1;
                sw_flit    <= '{dst_x: i_tx_dst_x, dst_y: i_tx_dst_y,
                                src_x: SELF_X, src_y: SELF_Y, payload: i_tx_payload};
            end else if (sw_out_xfer) begin
                o_sw_valid <= 1'b0;
            end
            if (sw_out_xfer)
                o_tx_count <= o_tx_count + 16'd1;
        end
    end

    // ---------------- RX path ----------------
    flit_t            in_flit;
    rx_entry_t        mem [RX_DEPTH];
    rx_entry_t        head;
    logic [RX_AW-1:0] wr_ptr;
    logic [RX_AW-1:0] rd_ptr;
    logic [RX_AW:0]   level;
    logic             sw_in_xfer;
    logic             dst_hit;
    logic             push;
    logic             pop;

    assign in_flit    = flit_t'(i_sw_data);
    assign dst_hit    = (in_flit.dst_x == SELF_X) && (in_flit.dst_y == SELF_Y);
    assign o_sw_ready = (level != FULL_LEVEL);
    assign sw_in_xfer = i_sw_valid && o_sw_ready;
    assign push       = sw_in_xfer && dst_hit;
    assign o_rx_valid = (level != '0);
    assign pop        = o_rx_valid && i_rx_ready;

    assign head         = mem[rd_ptr];
    assign o_rx_src_x   = head.src_x;
    assign o_rx_src_y   = head.src_y;
    assign o_rx_payload = head.payload;
    assign o_rx_level   = level;

    // Storage needs no reset: entries are only visible through level.
    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr] <= '{src_x: in_flit.src_x, src_y: in_flit.src_y,
                             payload: in_flit.payload};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            o_misroute <= 1'b0;
            o_rx_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                level <= level + 1'b1;
            else if (!push && pop)
                level <= level - 1'b1;
            if (push)
                o_rx_count <= o_rx_count + 16'd1;
            // Misrouted flits are still consumed so the switch port never wedges.
            if (sw_in_xfer && !dst_hit)
                o_misroute <= 1'b1;
        end
    end

endmodule
